// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: three producers share one register-file write port.
// One-cycle registered latency; losers see req_ready low and must hold their request.
module wb_arbiter #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [2:0]                     req_valid,
   input  logic [2:0][REG_ADDR_WIDTH-1:0] req_rd,
   input  logic [2:0][XLEN-1:0]           req_data,
   output logic [2:0]                     req_ready,
   input  logic                           stall,
   output logic                           wr_en,
   output logic [REG_ADDR_WIDTH-1:0]      rd,
   output logic [XLEN-1:0]                write_data,
   output logic [CNT_WIDTH-1:0]           conflict_cnt
);

   logic [1:0] last_grant;
   logic [1:0] p0, p1, p2;
   logic [1:0] grant_idx;
   logic       grant_vld;
   logic       contention;

   function automatic logic [1:0] rr_next(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search order rotates so the most recent winner is considered last.
   assign p0 = rr_next(last_grant);
   assign p1 = rr_next(p0);
   assign p2 = rr_next(p1);

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = p0;
      if (reset_n && !stall) begin
         if (req_valid[p0]) begin
            grant_vld = 1'b1;
            grant_idx = p0;
         end else if (req_valid[p1]) begin
            grant_vld = 1'b1;
            grant_idx = p1;
         end else if (req_valid[p2]) begin
            grant_vld = 1'b1;
            grant_idx = p2;
         end
      end
      req_ready = 3'b000;
      if (grant_vld) req_ready[grant_idx] = 1'b1;
   end

   assign contention = (req_valid[0] & req_valid[1]) |
                       (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant   <= 2'd2;
         wr_en        <= 1'b0;
         rd           <= '0;
         write_data   <= '0;
         conflict_cnt <= '0;
      end else begin
         // A write to x0 still consumes the grant but never reaches the register file.
         wr_en <= grant_vld && (req_rd[grant_idx] != '0);
         if (grant_vld) begin
            last_grant <= grant_idx;
            rd         <= req_rd[grant_idx];
            write_data <= req_data[grant_idx];
         end
         if (contention && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a round-robin reference model queues expected writes.
module tb_wb_arbiter;
   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int CW   = 16;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   stall = 1'b0;
   logic [2:0]             req_valid = 3'b000;
   logic [2:0][RW-1:0]     req_rd = '0;
   logic [2:0][XLEN-1:0]   req_data = '0;
   logic [2:0]             req_ready;
   logic                   wr_en;
   logic [RW-1:0]          rd;
   logic [XLEN-1:0]        write_data;
   logic [CW-1:0]          conflict_cnt;

   typedef struct packed {
      logic            wr;
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] data;
   } exp_t;

   exp_t            exp_q[$];
   int              n_checks = 0;
   int              n_fail = 0;
   logic [1:0]      m_last;
   logic [CW-1:0]   m_cnt;
   logic [2:0]      m_ready;
   logic [2:0]      obs_ready;
   logic            exp_wr;
   logic [RW-1:0]   exp_rd;
   logic [XLEN-1:0] exp_data;

   wb_arbiter #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rd(req_rd),
      .req_data(req_data), .req_ready(req_ready), .stall(stall), .wr_en(wr_en),
      .rd(rd), .write_data(write_data), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      exp_q.delete();
      m_last   = 2'd2;
      m_cnt    = '0;
      m_ready  = 3'b000;
      exp_wr   = 1'b0;
      exp_rd   = '0;
      exp_data = '0;
   endtask

   // One arbitration cycle: sample ready mid-cycle, update the model, return at posedge+1.
   task automatic step();
      logic [1:0] p;
      logic [1:0] g;
      logic       found;
      exp_t       e;
      @(negedge clk);
      obs_ready = req_ready;
      m_ready = 3'b000;
      found = 1'b0;
      g = 2'd0;
      p = m_last;
      if (!stall) begin
         for (int k = 0; k < 3; k++) begin
            p = (p == 2'd2) ? 2'd0 : p + 2'd1;
            if (!found && req_valid[p]) begin
               found = 1'b1;
               g = p;
            end
         end
      end
      if ($countones(req_valid) >= 2 && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (found) begin
         m_ready[g] = 1'b1;
         e.wr = (req_rd[g] != '0);
         e.rd = req_rd[g];
         e.data = req_data[g];
         exp_q.push_back(e);
         m_last = g;
      end
      @(posedge clk);
      #1;
      exp_wr = 1'b0;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         exp_wr = e.wr;
         exp_rd = e.rd;
         exp_data = e.data;
      end
      req_valid = req_valid & ~m_ready;
   endtask

   task automatic do_reset();
      req_valid = 3'b000;
      stall = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_valid = 3'b111;
      #3;
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
      n_checks++; if (rd !== '0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", rd); end
      n_checks++; if (write_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", write_data); end
      n_checks++; if (conflict_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt); end
      req_valid = 3'b000;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_priority_sequence();
      logic [2:0] er;
      req_rd[0] = 5'd1; req_rd[1] = 5'd2; req_rd[2] = 5'd3;
      req_data[0] = 32'hA0; req_data[1] = 32'hA1; req_data[2] = 32'hA2;
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
         step();
         er = 3'b001 << i;
         n_checks++; if (obs_ready !== er) begin n_fail++; $display("FAIL seq_ready[%0d] got=%b exp=%b", i, obs_ready, er); end
         n_checks++; if (wr_en !== 1'b1 || rd !== RW'(i + 1)) begin n_fail++; $display("FAIL seq_write[%0d] got=%b/%0d exp=1/%0d", i, wr_en, rd, i + 1); end
         n_checks++; if (write_data !== exp_data) begin n_fail++; $display("FAIL seq_data[%0d] got=%h exp=%h", i, write_data, exp_data); end
      end
      n_checks++; if (conflict_cnt !== 16'd2) begin n_fail++; $display("FAIL seq_cnt got=%0d exp=2", conflict_cnt); end
   endtask

   task automatic test_rd_zero();
      req_rd[1] = '0;
      req_data[1] = 32'hDEADBEEF;
      req_valid = 3'b010;
      step();
      n_checks++; if (obs_ready !== 3'b010) begin n_fail++; $display("FAIL rd0_ready got=%b exp=010", obs_ready); end
      n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rd0_wr_en got=%b exp=0", wr_en); end
      n_checks++; if (rd !== '0) begin n_fail++; $display("FAIL rd0_rd got=%0d exp=0", rd); end
      n_checks++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd0_data got=%h exp=deadbeef", write_data); end
   endtask

   task automatic test_stall();
      do_reset();
      req_rd[0] = 5'd9; req_rd[2] = 5'd10;
      req_data[0] = 32'h900; req_data[2] = 32'hA00;
      req_valid = 3'b101;
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++; if (obs_ready !== 3'b000 || wr_en !== 1'b0) begin n_fail++; $display("FAIL stall_block[%0d] got=%b/%b exp=000/0", i, obs_ready, wr_en); end
      end
      n_checks++; if (conflict_cnt !== 16'd4) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=4", conflict_cnt); end
      stall = 1'b0;
      step();
      n_checks++; if (obs_ready !== 3'b001) begin n_fail++; $display("FAIL stall_release got=%b exp=001", obs_ready); end
      n_checks++; if (wr_en !== 1'b1 || rd !== 5'd9 || write_data !== 32'h900) begin n_fail++; $display("FAIL stall_write0 got=%b/%0d/%h exp=1/9/900", wr_en, rd, write_data); end
      step();
      n_checks++; if (obs_ready !== 3'b100) begin n_fail++; $display("FAIL stall_second got=%b exp=100", obs_ready); end
   endtask

   task automatic test_same_rd();
      req_rd[0] = 5'd5; req_rd[2] = 5'd5;
      req_data[0] = 32'h11; req_data[2] = 32'h22;
      req_valid = 3'b101;
      step();
      n_checks++; if (obs_ready !== 3'b001 || write_data !== 32'h11) begin n_fail++; $display("FAIL same_rd_first got=%b/%h exp=001/11", obs_ready, write_data); end
      step();
      n_checks++; if (obs_ready !== 3'b100 || wr_en !== 1'b1) begin n_fail++; $display("FAIL same_rd_second got=%b/%b exp=100/1", obs_ready, wr_en); end
      n_checks++; if (rd !== 5'd5 || write_data !== 32'h22) begin n_fail++; $display("FAIL same_rd_final got=%0d/%h exp=5/22", rd, write_data); end
   endtask

   task automatic test_async_reset();
      req_rd[1] = 5'd7;
      req_data[1] = 32'h77;
      req_valid = 3'b010;
      step();
      n_checks++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL ar_inflight got=%b exp=1", wr_en); end
      req_valid = 3'b111;
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (wr_en !== 1'b0 || rd !== '0 || write_data !== '0) begin n_fail++; $display("FAIL ar_outputs got=%b/%0d/%h exp=0/0/0", wr_en, rd, write_data); end
      n_checks++; if (conflict_cnt !== '0 || req_ready !== 3'b000) begin n_fail++; $display("FAIL ar_cnt_ready got=%0d/%b exp=0/000", conflict_cnt, req_ready); end
      #1 reset_n = 1'b1;
      model_reset();
      step();
      n_checks++; if (obs_ready !== 3'b001) begin n_fail++; $display("FAIL ar_first_grant got=%b exp=001", obs_ready); end
      req_valid = 3'b000;
      step();
   endtask

   task automatic test_fairness();
      int wait2;
      int max_wait;
      wait2 = 0;
      max_wait = 0;
      req_valid = 3'b100;
      for (int i = 0; i < 1000; i++) begin
         step();
         n_checks++; if (obs_ready !== m_ready) begin n_fail++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, obs_ready, m_ready); end
         n_checks++; if (wr_en !== exp_wr || rd !== exp_rd || write_data !== exp_data) begin n_fail++; $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, wr_en, rd, write_data, exp_wr, exp_rd, exp_data); end
         if (obs_ready[2]) wait2 = 0; else wait2++;
         if (wait2 > max_wait) max_wait = wait2;
         if (!req_valid[2]) begin
            req_valid[2] = 1'b1;
            req_rd[2] = RW'($urandom);
            req_data[2] = $urandom;
         end
         for (int r = 0; r < 2; r++) begin
            if (!req_valid[r] && $urandom_range(1, 0) == 1) begin
               req_valid[r] = 1'b1;
               req_rd[r] = RW'($urandom);
               req_data[r] = $urandom;
            end
         end
      end
      n_checks++; if (max_wait >= 3) begin n_fail++; $display("FAIL rr_starvation got=%0d exp<3", max_wait); end
      n_checks++; if (conflict_cnt !== m_cnt) begin n_fail++; $display("FAIL rr_cnt got=%0d exp=%0d", conflict_cnt, m_cnt); end
   endtask

   task automatic test_saturation();
      stall = 1'b1;
      req_valid = 3'b111;
      repeat (65540) @(posedge clk);
      #1;
      n_checks++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got=%h exp=ffff", conflict_cnt); end
      @(posedge clk);
      #1;
      n_checks++; if (conflict_cnt !== 16'hFFFF || wr_en !== 1'b0) begin n_fail++; $display("FAIL sat_hold got=%h/%b exp=ffff/0", conflict_cnt, wr_en); end
      stall = 1'b0;
      req_valid = 3'b000;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_priority_sequence();
      test_rd_zero();
      test_stall();
      test_same_rd();
      test_async_reset();
      test_fairness();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
